irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 28 ++
 rtl/irq_ctrl_if.sv | 32 +++
 rtl/irq_prio_enc.sv | 35 +++
 rtl/irq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared definitions for the interrupt controller: register
//                offsets, controller FSM states and the claim-ID width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  // Claim IDs are source index + 1, so 31 sources need 5 bits (0 = none).
  localparam int ID_W = 5;

  localparam logic [31:0] ADR_PENDING = 32'h0000_0000;
  localparam logic [31:0] ADR_ENABLE  = 32'h0000_0004;
  localparam logic [31:0] ADR_MODE    = 32'h0000_0008;
  localparam logic [31:0] ADR_CLAIM   = 32'h0000_000C;
  // Highest decoded offset; anything above answers with an error.
  localparam logic [31:0] ADR_LAST    = 32'h0000_000C;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_if.sv
// ============================================================================
//  Interface   : wb_bus_t
//  Description : Wishbone classic register-access bus, no wait states.
//  Ports       : cyc/stb/we/adr/sel/dat_ms driven by master,
//                dat_sm/ack/err driven by slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_bus_t;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms,
    input  dat_sm, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms,
    output dat_sm, ack, err
  );
endinterface

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Lowest-index-first priority encoder.
//  Ports       : req_i   - request vector (N_SRC bits)
//                valid_o - any request set
//                id_o    - lowest set index + 1, 0 when none
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  id_o
);

  // Scan from the top down so the lowest set index is the last to win.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  Module      : irq_ctrl
//  Description : Interrupt controller with per-source edge/level mode,
//                enable mask and a claim/complete handshake.
//  Ports       : clk     - clock, rising edge
//                rstn_i  - asynchronous active-low reset
//                irq_i   - interrupt request lines (N_SRC)
//                irq_o   - interrupt request to the core
//                wb_bus  - Wishbone slave for PENDING/ENABLE/MODE/CLAIM
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic [N_SRC-1:0] irq_i,
  output logic             irq_o,
  wb_bus_t.slave           wb_bus
);

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q,  enable_d;
  logic [N_SRC-1:0] mode_q,    mode_d;
  logic [N_SRC-1:0] irq_q,     irq_d;
  logic [ID_W-1:0]  claimed_id_q, claimed_id_d;
  state_e           state_q,   state_d;

  logic             bus_req;
  logic             bad_adr;
  logic             wr_en;
  logic             rd_en;
  logic [N_SRC-1:0] wmask;
  logic [N_SRC-1:0] wdata;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic             prio_valid;
  logic [ID_W-1:0]  prio_id;
  logic             claim_take;
  logic             claim_done;
  logic [31:0]      rdata;
  logic             unused_dat;

  // ---------------------------------------------------------------- bus
  assign bus_req = wb_bus.cyc & wb_bus.stb;
  assign bad_adr = (wb_bus.adr > ADR_LAST);
  // Erroring accesses must not touch any register.
  assign wr_en   = bus_req & ~bad_adr &  wb_bus.we;
  assign rd_en   = bus_req & ~bad_adr & ~wb_bus.we;

  assign wb_bus.ack    = bus_req;
  assign wb_bus.err    = bus_req & bad_adr;
  assign wb_bus.dat_sm = rdata;

  assign wdata      = wb_bus.dat_ms[N_SRC-1:0];
  assign unused_dat = ^wb_bus.dat_ms[31:N_SRC];

  always_comb begin
    wmask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      wmask[i] = wb_bus.sel[i/8];
    end
  end

  // ------------------------------------------------------ source sampling
  assign irq_d    = irq_i;
  assign edge_det = irq_i & ~irq_q;
  assign w1c      = (wr_en && wb_bus.adr == ADR_PENDING) ? (wdata & wmask) : '0;

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req_i   (pending_q & enable_q),
    .valid_o (prio_valid),
    .id_o    (prio_id)
  );

  // A claim is taken only by a read in IDLE that finds something to return.
  assign claim_take = rd_en && (wb_bus.adr == ADR_CLAIM) &&
                      (state_q == ST_IDLE) && prio_valid;
  assign claim_done = wr_en && (wb_bus.adr == ADR_CLAIM) &&
                      (state_q == ST_SERVICE) && wb_bus.sel[0] &&
                      (wb_bus.dat_ms[7:0] == 8'(claimed_id_q));

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_clr[i] = claim_take && (prio_id == ID_W'(i + 1));
    end
  end

  // Edge sources: set dominates any clear in the same cycle.
  // Level sources: simply track the input, clears are ignored.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) begin
        pending_d[i] = edge_det[i] | (pending_q[i] & ~(w1c[i] | claim_clr[i]));
      end else begin
        pending_d[i] = irq_i[i];
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_en && wb_bus.adr == ADR_ENABLE) begin
      enable_d = (enable_q & ~wmask) | (wdata & wmask);
    end
    if (wr_en && wb_bus.adr == ADR_MODE) begin
      mode_d = (mode_q & ~wmask) | (wdata & wmask);
    end
  end

  // ------------------------------------------------------------------ FSM
  always_comb begin
    state_d      = state_q;
    claimed_id_d = claimed_id_q;
    case (state_q)
      ST_IDLE: begin
        if (claim_take) begin
          state_d      = ST_SERVICE;
          claimed_id_d = prio_id;
        end
      end
      ST_SERVICE: begin
        if (claim_done) begin
          state_d      = ST_IDLE;
          claimed_id_d = '0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        claimed_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q    <= '0;
      enable_q     <= '0;
      mode_q       <= '0;
      irq_q        <= '0;
      claimed_id_q <= '0;
      state_q      <= ST_IDLE;
    end else begin
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      irq_q        <= irq_d;
      claimed_id_q <= claimed_id_d;
      state_q      <= state_d;
    end
  end

  assign irq_o = (state_q == ST_IDLE) && |(pending_q & enable_q);

  // ------------------------------------------------------------ read mux
  always_comb begin
    rdata = '0;
    if (!bad_adr) begin
      case (wb_bus.adr)
        ADR_PENDING: rdata[N_SRC-1:0] = pending_q;
        ADR_ENABLE:  rdata[N_SRC-1:0] = enable_q;
        ADR_MODE:    rdata[N_SRC-1:0] = mode_q;
        ADR_CLAIM:   rdata[ID_W-1:0]  = (state_q == ST_SERVICE) ? claimed_id_q : prio_id;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Self-checking bench for irq_ctrl; behavioural model plus
//                directed scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;
  localparam int N = 8;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] irq  = '0;
  logic         irq_o;

  wb_bus_t bus ();

  irq_ctrl #(.N_SRC(N)) dut (
    .clk    (clk),
    .rstn_i (rstn),
    .irq_i  (irq),
    .irq_o  (irq_o),
    .wb_bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit [N-1:0] m_pend, m_en, m_mode, m_prev;
  bit         m_svc;
  int         m_cid;

  function automatic bit m_acc();
    return bus.cyc && bus.stb && (bus.adr <= 32'hC);
  endfunction

  function automatic bit [N-1:0] m_wmask();
    bit [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = bus.sel[i/8];
    return m;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      32'h0:   return 32'(m_pend);
      32'h4:   return 32'(m_en);
      32'h8:   return 32'(m_mode);
      32'hC:   return m_svc ? 32'(m_cid) : 32'(m_lowest());
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_claim_rd();
    return m_acc() && !bus.we && bus.adr == 32'hC && !m_svc && m_lowest() != 0;
  endfunction

  function automatic bit m_claim_wr();
    return m_acc() && bus.we && bus.adr == 32'hC && m_svc && bus.sel[0] &&
           (int'(bus.dat_ms[7:0]) == m_cid);
  endfunction

  function automatic bit [N-1:0] m_next_pend();
    bit [N-1:0] n;
    bit [N-1:0] wm;
    bit rise, clr;
    wm = m_wmask();
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        rise = irq[i] && !m_prev[i];
        clr  = (m_acc() && bus.we && bus.adr == 32'h0 && bus.dat_ms[i] && wm[i]) ||
               (m_claim_rd() && m_lowest() == i + 1);
        n[i] = rise ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
      end else begin
        n[i] = irq[i];
      end
    end
    return n;
  endfunction

  function automatic bit [N-1:0] m_next_rw(input bit [N-1:0] old, input logic [31:0] a);
    bit [N-1:0] wm;
    wm = m_wmask();
    if (m_acc() && bus.we && bus.adr == a)
      return (old & ~wm) | (bus.dat_ms[N-1:0] & wm);
    return old;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pend <= '0;
      m_en   <= '0;
      m_mode <= '0;
      m_prev <= '0;
      m_svc  <= 1'b0;
      m_cid  <= 0;
    end else begin
      m_pend <= m_next_pend();
      m_en   <= m_next_rw(m_en, 32'h4);
      m_mode <= m_next_rw(m_mode, 32'h8);
      m_prev <= irq;
      if (m_claim_rd()) begin
        m_svc <= 1'b1;
        m_cid <= m_lowest();
      end else if (m_claim_wr()) begin
        m_svc <= 1'b0;
        m_cid <= 0;
      end
    end
  end

  // Cycle-by-cycle comparison, well clear of the rising edge.
  always @(negedge clk) begin
    #2;
    chk("m_irq_o", 32'(irq_o), 32'(!m_svc && |(m_pend & m_en)));
    chk("m_ack",   32'(bus.ack), 32'(bus.cyc && bus.stb));
    chk("m_err",   32'(bus.err), 32'(bus.cyc && bus.stb && bus.adr > 32'hC));
    if (bus.cyc && bus.stb && !bus.we)
      chk("m_rdata", bus.dat_sm, m_read(bus.adr));
  end

  // ------------------------------------------------------------ stimulus
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = a; bus.dat_ms = d; bus.sel = s;
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
    bus.adr = a; bus.sel = 4'hF;
    #1 chk(nm, bus.dat_sm, exp);
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0;
  endtask

  task automatic pulse(input int b);
    irq[b] = 1'b1;
    @(negedge clk);
    irq[b] = 1'b0;
  endtask

  task automatic lit_irq(input string nm, input logic exp);
    #1 chk(nm, 32'(irq_o), 32'(exp));
  endtask

  initial begin
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.sel = '0; bus.dat_ms = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    lit_irq("rst_irq", 1'b0);
    rd(32'h0, 32'h0, "rst_pending");
    rd(32'h4, 32'h0, "rst_enable");
    rstn = 1'b1;
    @(negedge clk);

    // Edge source 0: one-cycle pulse, claim, pending clears.
    wr(32'h4, 32'h3, 4'hF);
    wr(32'h8, 32'h3, 4'hF);
    rd(32'h4, 32'h3, "enable_rw");
    pulse(0);
    lit_irq("edge_irq_1clk", 1'b1);
    rd(32'hC, 32'h1, "claim_src0");
    lit_irq("svc_irq_low", 1'b0);
    rd(32'h0, 32'h0, "claim_clears_pend");

    // Nested source during SERVICE; wrong-ID completion ignored.
    pulse(1);
    lit_irq("svc_masks_irq", 1'b0);
    rd(32'h0, 32'h2, "pend_latched_svc");
    wr(32'hC, 32'h2, 4'hF);
    rd(32'hC, 32'h1, "bad_complete_ignored");
    wr(32'hC, 32'h1, 4'hF);
    lit_irq("reassert_after_done", 1'b1);
    rd(32'hC, 32'h2, "claim_src1");
    wr(32'hC, 32'h2, 4'hF);

    // Level source 0 held high.
    wr(32'h8, 32'h0, 4'hF);
    wr(32'h4, 32'h1, 4'hF);
    irq[0] = 1'b1;
    @(negedge clk);
    rd(32'hC, 32'h1, "level_claim");
    wr(32'hC, 32'h1, 4'hF);
    lit_irq("level_reassert", 1'b1);
    irq[0] = 1'b0;
    @(negedge clk);
    rd(32'h0, 32'h0, "level_drop");

    // Set beats W1C in the same cycle on edge source 2.
    wr(32'h8, 32'h4, 4'hF);
    wr(32'h4, 32'h0, 4'hF);
    irq[2] = 1'b1;
    wr(32'h0, 32'h4, 4'hF);
    irq[2] = 1'b0;
    rd(32'h0, 32'h4, "set_wins_w1c");
    wr(32'h0, 32'h4, 4'hF);
    rd(32'h0, 32'h0, "w1c_clears");

    // Byte enables.
    wr(32'h4, 32'h55, 4'hE);
    rd(32'h4, 32'h0, "sel_masked");
    wr(32'h4, 32'h181, 4'h1);
    rd(32'h4, 32'h81, "sel_byte0");
    wr(32'h4, 32'h0, 4'hF);

    // Bad addresses and empty claim.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h10;
    #1;
    chk("err_ack", 32'(bus.ack), 32'h1);
    chk("err_err", 32'(bus.err), 32'h1);
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    wr(32'h14, 32'hFFFF_FFFF, 4'hF);
    rd(32'h4, 32'h0, "bad_wr_enable");
    rd(32'h8, 32'h4, "bad_wr_mode");
    rd(32'hC, 32'h0, "claim_none");
    wr(32'h4, 32'h4, 4'hF);
    pulse(2);
    lit_irq("idle_after_empty_claim", 1'b1);
    wr(32'h0, 32'h4, 4'hF);
    wr(32'h4, 32'h0, 4'hF);

    // Reset in the middle of SERVICE.
    wr(32'h4, 32'h1, 4'hF);
    wr(32'h8, 32'h1, 4'hF);
    pulse(0);
    rd(32'hC, 32'h1, "pre_reset_claim");
    rstn = 1'b0;
    lit_irq("reset_irq", 1'b0);
    rd(32'h4, 32'h0, "reset_enable");
    rd(32'h8, 32'h0, "reset_mode");
    rstn = 1'b1;
    @(negedge clk);
    wr(32'h4, 32'h1, 4'hF);
    wr(32'h8, 32'h1, 4'hF);
    pulse(0);
    lit_irq("post_reset_irq", 1'b1);
    wr(32'hC, 32'h1, 4'hF);
    lit_irq("stale_complete_ignored", 1'b1);
    rd(32'hC, 32'h1, "post_reset_claimable");
    wr(32'hC, 32'h1, 4'hF);

    // Disabling a source keeps its pending bit.
    pulse(0);
    wr(32'h4, 32'h0, 4'hF);
    rd(32'h0, 32'h1, "disable_keeps_pend");
    lit_irq("disabled_irq_low", 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
